// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, timer line
// index and timer control bit positions.
package irq_pkg;

    typedef enum logic [2:0] {
        IRQ_PENDING = 3'd0,
        IRQ_ENABLE  = 3'd1,
        IRQ_EDGE    = 3'd2,
        IRQ_COUNT   = 3'd3,
        IRQ_COMPARE = 3'd4,
        IRQ_CTRL    = 3'd5,
        IRQ_RAW     = 3'd6,
        IRQ_NONE    = 3'd7
    } irq_reg_e;

    localparam int          TIMER_LINE      = 7;
    localparam int          CTRL_EN_BIT     = 0;
    localparam int          CTRL_RELOAD_BIT = 1;
    localparam logic [31:0] COMPARE_RST     = 32'hFFFF_FFFF;

endpackage

// File: rtl/irq_if.sv
// Word-addressed register port between the memory stage and the interrupt
// controller.
interface irq_if;

    logic [2:0]  addr;
    logic        wr_en;
    logic [63:0] wr_data;
    logic [63:0] rd_data;

    modport master (output addr, output wr_en, output wr_data, input rd_data);
    modport slave  (input addr, input wr_en, input wr_data, output rd_data);

endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines, plus a one-cycle
// history flop used for rising-edge detection.
module irq_sync #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            prev_q <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            prev_q <= stage_q[DEPTH-1];
        end
    end

    assign sync_o = stage_q[DEPTH-1];
    assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: seven synchronised external lines plus a Count/Compare
// timer on line 7, latched as pending and masked into CP0's interrupt_source.
module irq_controller
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N_EXT       = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_EXT-1:0] irq_in,
    irq_if.slave             bus,
    output logic [7:0]       interrupt_source
);

    logic [N_EXT-1:0] sync, rise;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       enable_q, enable_d;
    logic [N_EXT-1:0] edge_q, edge_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             wr_pend, wr_count, wr_compare, match;
    logic             unused_wr_hi;

    irq_sync #(.WIDTH(N_EXT), .DEPTH(SYNC_STAGES)) u_sync (
        .clk     (clock),
        .rst     (reset),
        .async_i (irq_in),
        .sync_o  (sync),
        .rise_o  (rise)
    );

    assign wr_pend      = bus.wr_en && (bus.addr == IRQ_PENDING);
    assign wr_count     = bus.wr_en && (bus.addr == IRQ_COUNT);
    assign wr_compare   = bus.wr_en && (bus.addr == IRQ_COMPARE);
    assign match        = ctrl_q[CTRL_EN_BIT] && (count_q == compare_q);
    assign unused_wr_hi = ^bus.wr_data[63:32];

    always_comb begin
        pending_d = pending_q;
        enable_d  = enable_q;
        edge_d    = edge_q;
        count_d   = count_q;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;

        // Level lines track the synchroniser; edge lines give a new rise priority over W1C.
        for (int i = 0; i < N_EXT; i++) begin
            if (!edge_q[i])                       pending_d[i] = sync[i];
            else if (rise[i])                     pending_d[i] = 1'b1;
            else if (wr_pend && bus.wr_data[i])   pending_d[i] = 1'b0;
        end

        // A COMPARE write acknowledges the timer even against a simultaneous match.
        if (wr_compare)                                  pending_d[TIMER_LINE] = 1'b0;
        else if (match)                                  pending_d[TIMER_LINE] = 1'b1;
        else if (wr_pend && bus.wr_data[TIMER_LINE])     pending_d[TIMER_LINE] = 1'b0;

        if (wr_count)
            count_d = bus.wr_data[31:0];
        else if (ctrl_q[CTRL_EN_BIT])
            count_d = (match && ctrl_q[CTRL_RELOAD_BIT]) ? 32'd0 : count_q + 32'd1;

        if (bus.wr_en) begin
            case (bus.addr)
                IRQ_ENABLE:  enable_d  = bus.wr_data[7:0];
                IRQ_EDGE:    edge_d    = bus.wr_data[N_EXT-1:0];
                IRQ_COMPARE: compare_d = bus.wr_data[31:0];
                IRQ_CTRL:    ctrl_d    = bus.wr_data[1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            count_q   <= '0;
            compare_q <= COMPARE_RST;
            ctrl_q    <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            IRQ_PENDING: bus.rd_data = 64'(pending_q);
            IRQ_ENABLE:  bus.rd_data = 64'(enable_q);
            IRQ_EDGE:    bus.rd_data = 64'(edge_q);
            IRQ_COUNT:   bus.rd_data = 64'(count_q);
            IRQ_COMPARE: bus.rd_data = 64'(compare_q);
            IRQ_CTRL:    bus.rd_data = 64'(ctrl_q);
            IRQ_RAW:     bus.rd_data = 64'(sync);
            default:     bus.rd_data = '0;
        endcase
    end

    assign interrupt_source = pending_q & enable_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomised checks of irq_controller against a rule-level model
// of the register file, timer and delayed input lines.
module tb_irq_controller;

    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] irq_in;
    logic [7:0] interrupt_source;

    irq_if bus();

    irq_controller #(.SYNC_STAGES(SYNC), .N_EXT(7)) dut (
        .clock            (clock),
        .reset            (reset),
        .irq_in           (irq_in),
        .bus              (bus),
        .interrupt_source (interrupt_source)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: irq_in seen SYNC edges ago is the synchronised view.
    logic [6:0]  m_hist [SYNC];
    logic [6:0]  m_prev;
    logic [7:0]  m_pend, m_en;
    logic [6:0]  m_edge;
    logic [31:0] m_cnt, m_cmp;
    logic [1:0]  m_ctrl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
        m_prev = '0; m_pend = '0; m_en = '0; m_edge = '0;
        m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_ctrl = '0;
    endtask

    function automatic logic [63:0] mread(input logic [2:0] a);
        case (a)
            3'd0: return {56'd0, m_pend};
            3'd1: return {56'd0, m_en};
            3'd2: return {57'd0, m_edge};
            3'd3: return {32'd0, m_cnt};
            3'd4: return {32'd0, m_cmp};
            3'd5: return {62'd0, m_ctrl};
            3'd6: return {57'd0, m_hist[SYNC-1]};
            default: return 64'd0;
        endcase
    endfunction

    task automatic cycle();
        logic [7:0]  np;
        logic [6:0]  s, r, din;
        logic [31:0] nc;
        logic [63:0] d;
        logic [2:0]  a;
        logic        we, w1c, mt;
        we = bus.wr_en; a = bus.addr; d = bus.wr_data; din = irq_in;
        s = m_hist[SYNC-1];
        r = s & ~m_prev;
        w1c = we && (a == 3'd0);
        np = m_pend;
        for (int i = 0; i < 7; i++) begin
            if (!m_edge[i])           np[i] = s[i];
            else if (r[i])            np[i] = 1'b1;
            else if (w1c && d[i])     np[i] = 1'b0;
        end
        mt = m_ctrl[0] && (m_cnt == m_cmp);
        if (we && a == 3'd4)          np[7] = 1'b0;
        else if (mt)                  np[7] = 1'b1;
        else if (w1c && d[7])         np[7] = 1'b0;
        nc = m_cnt;
        if (we && a == 3'd3)          nc = d[31:0];
        else if (m_ctrl[0])           nc = (mt && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
        @(posedge clock);
        if (!reset) begin
            m_pend = np; m_cnt = nc; m_prev = s;
            for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = din;
            if (we) begin
                case (a)
                    3'd1: m_en   = d[7:0];
                    3'd2: m_edge = d[6:0];
                    3'd4: m_cmp  = d[31:0];
                    3'd5: m_ctrl = d[1:0];
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] d);
        bus.addr = a; bus.wr_en = 1'b1; bus.wr_data = d;
        cycle();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        bus.addr = a; #1;
        chk(tag, bus.rd_data, mread(a));
    endtask

    task automatic rdl(input logic [2:0] a, input logic [63:0] exp, input string tag);
        bus.addr = a; #1;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic src(input string tag);
        chk(tag, {56'd0, interrupt_source}, {56'd0, m_pend & m_en});
    endtask

    task automatic srcl(input logic [7:0] exp, input string tag);
        chk(tag, {56'd0, interrupt_source}, {56'd0, exp});
    endtask

    initial begin
        reset = 1'b1; irq_in = 7'h7F;
        bus.addr = '0; bus.wr_en = 1'b0; bus.wr_data = '0;
        model_reset();

        // Reset with all lines high, then level-mode latching.
        cycles(3);
        srcl(8'h00, "reset_src");
        rdl(3'd4, 64'hFFFF_FFFF, "reset_compare");
        reset = 1'b0;
        cycles(3);
        rdl(3'd6, 64'h7F, "raw_synced");
        rdl(3'd0, 64'h7F, "pend_level");
        srcl(8'h00, "src_masked");
        wr(3'd1, 64'h7F);
        srcl(8'h7F, "src_enabled");

        // Edge mode on line 0, single-cycle pulse.
        irq_in = 7'h00;
        cycles(3);
        wr(3'd2, 64'h01);
        wr(3'd1, 64'h01);
        wr(3'd0, 64'h01);
        srcl(8'h00, "edge_cleared");
        irq_in = 7'h01; cycle();
        irq_in = 7'h00; cycle();
        srcl(8'h00, "edge_lat2");
        cycle();
        srcl(8'h01, "edge_lat3");
        cycles(3);
        srcl(8'h01, "edge_hold");
        wr(3'd0, 64'h01);
        srcl(8'h00, "edge_w1c");

        // Second rise coinciding with W1C: set wins.
        irq_in = 7'h01; cycle(); irq_in = 7'h00; cycles(2);
        irq_in = 7'h01; cycle(); irq_in = 7'h00; cycle();
        wr(3'd0, 64'h01);
        srcl(8'h01, "rise_vs_w1c");
        rd(3'd0, "rise_vs_w1c_pend");

        // Timer with auto-reload.
        wr(3'd3, 64'd0);
        wr(3'd4, 64'd5);
        wr(3'd5, 64'h3);
        wr(3'd1, 64'h80);
        for (int k = 0; k < 4; k++) begin
            cycle();
            rd(3'd3, "reload_count");
            src("reload_src");
        end
        cycle();
        rdl(3'd3, 64'd0, "reload_to_zero");
        srcl(8'h80, "timer_match");
        wr(3'd4, 64'd5);
        srcl(8'h00, "compare_wr_clear");

        // Wrap without reload.
        wr(3'd5, 64'h0);
        wr(3'd3, 64'hFFFF_FFFE);
        wr(3'd4, 64'd1);
        wr(3'd5, 64'h1);
        cycles(3);
        rdl(3'd3, 64'd1, "wrap_count1");
        cycle();
        rdl(3'd3, 64'd2, "wrap_count2");
        srcl(8'h80, "wrap_match");

        // COMPARE write coinciding with match: write wins.
        wr(3'd5, 64'h0);
        wr(3'd0, 64'h80);
        wr(3'd3, 64'd10);
        wr(3'd4, 64'd12);
        wr(3'd5, 64'h1);
        cycles(2);
        wr(3'd4, 64'd99);
        srcl(8'h00, "cmpwr_vs_match");
        rd(3'd0, "cmpwr_vs_match_pend");

        // W1C coinciding with match: set wins.
        wr(3'd5, 64'h0);
        wr(3'd3, 64'd20);
        wr(3'd4, 64'd21);
        wr(3'd5, 64'h1);
        cycle();
        wr(3'd0, 64'h80);
        srcl(8'h80, "w1c_vs_match");

        // Asynchronous reset mid-count with everything pending.
        wr(3'd2, 64'h0);
        irq_in = 7'h7F;
        cycles(3);
        wr(3'd1, 64'hFF);
        rdl(3'd0, 64'hFF, "all_pending");
        srcl(8'hFF, "all_src");
        reset = 1'b1;
        #1;
        srcl(8'h00, "async_rst_src");
        rdl(3'd0, 64'h0, "async_rst_pend");
        rdl(3'd3, 64'h0, "async_rst_count");
        rdl(3'd4, 64'hFFFF_FFFF, "async_rst_compare");
        rdl(3'd6, 64'h0, "async_rst_raw");
        model_reset();
        cycles(2);
        reset = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  a;
            logic [63:0] d;
            irq_in = 7'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = 3'($urandom_range(0, 7));
                if (a == 3'd3 || a == 3'd4) d = 64'($urandom_range(0, 30));
                else                        d = {$urandom, $urandom};
                wr(a, d);
            end else begin
                cycle();
            end
            rd(3'($urandom_range(0, 7)), "rand_rd");
            src("rand_src");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Memory-mapped interrupt controller that produces the 8-bit interrupt_source vector consumed by CP0's Cause[15:8].
- Lines 0-6 come from asynchronous external devices.
- Line 7 is an internal Count/Compare timer.
- The block synchronises inputs, latches them as pending (edge or level), masks them with a software enable, and exposes all state through a small word-addressed register port driven by the memory stage.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (min 2)
N_EXT, 7, number of external interrupt lines (fixed to 7; line 7 is reserved for the timer)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
irq_in  input  7  raw external interrupt lines, asynchronous to clock
addr  input  3  register word index
wr_en  input  1  register write strobe, one cycle per write
wr_data  input  64  write data (low 32 bits used)
rd_data  output  64  read data for addr, combinational, zero-extended
interrupt_source  output  8  pending & enable, to CP0 interrupt_source

Behaviour:
- Register map (addr):
  0 PENDING[7:0], W1C
  1 ENABLE[7:0], RW
  2 EDGE_MODE[6:0], RW (1 = rising-edge, 0 = level)
  3 TIMER_COUNT[31:0], RW
  4 TIMER_COMPARE[31:0], RW
  5 TIMER_CTRL[1:0], RW (bit0 = enable, bit1 = auto_reload)
  6 RAW_STATUS[6:0], RO (synchronised inputs)
  7 reads 0 and writes are ignored.
  Unused upper bits read 0.
- Reset values: PENDING 0, ENABLE 0, EDGE_MODE 0, COUNT 0, COMPARE 0xFFFF_FFFF, CTRL 0, synchroniser and edge flops 0. interrupt_source is therefore 0 during and after reset.
- Synchroniser: irq_in passes through SYNC_STAGES flops into sync[6:0]. A prev[6:0] flop holds the previous sync value. rise = sync & ~prev.
- Level lines (EDGE_MODE = 0): PENDING[i] <= sync[i] every cycle. W1C to these bits has no effect.
- Edge lines (EDGE_MODE = 1):
  - rise[i] sets PENDING[i]; W1C clears it.
  - If a rise and a W1C occur in the same cycle, set wins.
  - Changing a line's mode does not clear it; the new mode takes effect on the next edge.
- Latency (SYNC_STAGES = 2): irq_in rises before edge 1, sync is high after edge 2, PENDING is set at edge 3. interrupt_source reflects PENDING & ENABLE combinationally from the registers, so it is also set at edge 3.
- Timer:
  - When CTRL.enable = 1, COUNT increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - match = enable && (COUNT == COMPARE). On match, PENDING[7] is set at the same edge.
  - With auto_reload = 1, the next COUNT after a match is 0; otherwise COUNT keeps incrementing.
  - A software write to COUNT overrides both increment and reload in that cycle.
  - A write to COMPARE clears PENDING[7] (MIPS convention). If a match coincides with the COMPARE write, the write wins and PENDING[7] ends up 0.
  - W1C on PENDING[7] also clears it. If the match and the W1C coincide, set wins.
  - A disabled timer holds COUNT and never matches.
- Writes take effect at the clock edge. rd_data shows the pre-write value in the write cycle.
- Reset asserted mid-operation clears all state asynchronously, including in-flight synchroniser bits. No pending interrupt survives reset.
- Side effects: none on read. ENABLE only masks the output; PENDING continues to latch masked lines.

Decomposition:
- Shared package irq_pkg holds:
  - register index constants (IRQ_PENDING = 3'd0 … IRQ_RAW = 3'd6)
  - TIMER_LINE = 7
  - CTRL bit positions
  - COMPARE reset constant
- Sub-module irq_sync (parameterised width and depth) holds the synchroniser plus the prev flop and outputs sync and rise. The pending/timer logic stays in irq_controller.

Test Plan:
- Reset with all lines high, then release -> interrupt_source = 0. Read RAW_STATUS = 0x7F once synced, PENDING = 0x7F (level mode), interrupt_source stays 0 until ENABLE is written.
- EDGE_MODE = 0x01, ENABLE = 0x01, pulse irq_in[0] for 1 cycle -> interrupt_source = 0x01 at edge 3 and holds after the pulse ends. Write PENDING = 0x01 -> cleared next edge.
- Edge line 0: a second rise in the same cycle as a W1C -> PENDING[0] stays 1.
- COUNT = 0, COMPARE = 5, CTRL = 0x3, ENABLE = 0x80 -> PENDING[7] set on the match edge, COUNT reads 0 next cycle. Write COMPARE = 5 -> PENDING[7] = 0.
- COUNT = 0xFFFF_FFFE, COMPARE = 1, CTRL = 0x1 -> wraps to 0, matches at COUNT = 1 and keeps counting (reads 2 next). A COMPARE write coinciding with the match leaves PENDING[7] = 0.
- Assert reset asynchronously mid-count with PENDING = 0xFF -> all registers return to reset values immediately, with no clock edge.
